// File: rtl/stream_read_arbiter_if.sv
// Request/response and BRAM read-port signals of the stream read arbiter.
// The slave modport is the arbiter; the master modport drives requesters and the BRAM.
interface stream_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 9,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [NUM_REQ-1:0]        rready;
    logic [DATA_W-1:0]         rdata;
    logic                      rd_start;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_done;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output req, addr, rready, rd_data, rd_done,
        input  gnt, rvalid, rdata, rd_start, rd_addr, busy, timeout_err
    );

    modport slave (
        input  req, addr, rready, rd_data, rd_done,
        output gnt, rvalid, rdata, rd_start, rd_addr, busy, timeout_err
    );
endinterface

// File: rtl/stream_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters,
// with a single outstanding read and a per-read completion timeout.
module stream_read_arbiter #(
    parameter int unsigned NUM_REQ = 9,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    stream_read_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_timeout_err;

    logic                w_win_vld;
    logic [IDX_W-1:0]    w_win_idx;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [NUM_REQ-1:0]  w_rvalid;
    logic                w_rd_start;
    logic                w_done;
    logic                w_expire;
    logic                w_accept;

    // Search upward from r_ptr, wrapping at NUM_REQ; first requester found wins.
    always_comb begin
        int unsigned      w_cand;
        logic [IDX_W-1:0] w_cand_idx;
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_win_addr = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_cand = 32'(r_ptr) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = IDX_W'(w_cand);
            if (!w_win_vld && bus.req[w_cand_idx]) begin
                w_win_vld  = 1'b1;
                w_win_idx  = w_cand_idx;
                w_win_addr = bus.addr[w_cand*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_rvalid    = '0;
        w_rd_start  = 1'b0;
        w_done      = 1'b0;
        w_expire    = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_win_vld) begin
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_gnt[r_idx] = 1'b1;
                w_rd_start   = 1'b1;
                w_state_nxt  = StWait;
            end
            StWait: begin
                // A completion arriving on the last allowed cycle still counts.
                if (bus.rd_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = StResp;
                end else if (r_cnt == CNT_MAX) begin
                    w_expire    = 1'b1;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                w_rvalid[r_idx] = 1'b1;
                if (bus.rready[r_idx]) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx         <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_rd_addr     <= '0;
            r_rdata       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == StIdle && w_win_vld) begin
                r_idx     <= w_win_idx;
                r_rd_addr <= w_win_addr;
            end
            if (r_state == StIssue) begin
                r_cnt <= '0;
            end else if (r_state == StWait && !w_done && !w_expire) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done) begin
                r_rdata <= bus.rd_data;
            end else if (w_expire) begin
                r_rdata <= '0;
            end
            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end
            if (w_accept) begin
                r_ptr <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.rvalid      = w_rvalid;
    assign bus.rd_start    = w_rd_start;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.rdata       = r_rdata;
    assign bus.busy        = (r_state != StIdle);
    assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_stream_read_arbiter.sv
// Scoreboard bench for stream_read_arbiter: a small BRAM model answers rd_start and
// expected responses are queued when requests are driven, then compared on rvalid&rready.
module tb_stream_read_arbiter;
    localparam int unsigned NR = 9;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned TO = 255;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;

    stream_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    stream_read_arbiter #(
        .NUM_REQ(NR),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t          sb[$];
    int            gnt_log[$];
    int            n_checks;
    int            n_errors;
    int            pend;
    int            bram_delay;
    bit            bram_en;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] bram_xor;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < int'(NR); i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        return {4{a}} ^ bram_xor;
    endfunction

    task automatic push_exp(input int idx, input logic [DW-1:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        check("gnt_onehot", $onehot0(bus.gnt), 1);
        check("rvalid_onehot", $onehot0(bus.rvalid), 1);
        check("start_with_gnt", bus.rd_start, |bus.gnt);
        if (|bus.gnt) gnt_log.push_back(oh_idx(bus.gnt));
        if (|(bus.rvalid & bus.rready)) begin
            if (sb.size() == 0) begin
                check("sb_empty", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("resp_idx", oh_idx(bus.rvalid), e.idx);
                check("resp_data", bus.rdata, e.data);
            end
        end
        if (bus.rd_start && bram_en) begin
            pend      = bram_delay;
            pend_data = bram_word(bus.rd_addr);
        end
    endtask

    // Observe the current cycle at negedge, then drive the BRAM model just after posedge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        bus.rd_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.rd_done = 1'b1;
                bus.rd_data = pend_data;
            end
        end
    endtask

    task automatic wait_gnt(input int i, input int max);
        int n = 0;
        while (!bus.gnt[i] && n < max) begin
            tick();
            n++;
        end
        check("gnt_wait", bus.gnt[i], 1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < max) begin
            tick();
            n++;
        end
        check("drain_sb", sb.size(), 0);
        check("drain_idle", bus.busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_rvalid"}, bus.rvalid, 0);
        check({tag, "_start"}, bus.rd_start, 0);
        check({tag, "_rdaddr"}, bus.rd_addr, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        int n;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        bus.req     = '0;
        bus.addr    = '0;
        bus.rready  = '1;
        bus.rd_data = '0;
        bus.rd_done = 1'b0;
        bram_en     = 1'b1;
        bram_delay  = 1;
        pend        = 0;
        bram_xor    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        #2;
        check_all_zero("reset");
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Fairness: all requesters held high, immediate completion and acceptance.
        gnt_log.delete();
        for (int i = 0; i < int'(NR); i++) bus.addr[i*AW +: AW] = 32'h1000 + 32'(i) * 16;
        for (int k = 0; k < 10; k++) push_exp(k % 9, bram_word(32'h1000 + 32'(k % 9) * 16));
        bus.req = '1;
        n = 0;
        while (gnt_log.size() < 10 && n < 300) begin
            tick();
            n++;
        end
        bus.req = '0;
        check("f_grants", gnt_log.size(), 10);
        check("f_cycles", n, 38);
        for (int k = 0; k < gnt_log.size(); k++) check("f_order", gnt_log[k], k % 9);
        drain(100);

        // Single request with minimum latency.
        bram_xor = {4{32'hA5A5_A5A5 ^ 32'h40}};
        bus.addr[3*AW +: AW] = 32'h40;
        bus.req[3] = 1'b1;
        push_exp(3, {4{32'hA5A5_A5A5}});
        tick();
        check("s_gnt", bus.gnt, 9'h008);
        check("s_start", bus.rd_start, 1);
        check("s_rdaddr", bus.rd_addr, 32'h40);
        bus.req[3] = 1'b0;
        tick();
        check("s_rvalid_early", bus.rvalid, 0);
        tick();
        check("s_rvalid", bus.rvalid, 9'h008);
        check("s_rdata", bus.rdata, {4{32'hA5A5_A5A5}});
        tick();
        check("s_idle", bus.busy, 0);
        bram_xor = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        // Backpressure on requester 2 while requester 7 waits; other rready bits stay high.
        bus.rready = ~9'h004;
        bus.addr[2*AW +: AW] = 32'h200;
        bus.addr[7*AW +: AW] = 32'h700;
        bus.req[2] = 1'b1;
        push_exp(2, bram_word(32'h200));
        push_exp(7, bram_word(32'h700));
        wait_gnt(2, 10);
        bus.req[2] = 1'b0;
        bus.req[7] = 1'b1;
        n = 0;
        while (!bus.rvalid[2] && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            check("bp_rvalid", bus.rvalid, 9'h004);
            check("bp_rdata", bus.rdata, bram_word(32'h200));
            check("bp_busy", bus.busy, 1);
            check("bp_nognt", bus.gnt, 0);
            tick();
        end
        bus.rready = '1;
        tick();
        check("bp_idle", bus.busy, 0);
        tick();
        check("bp_next_gnt", bus.gnt, 9'h080);
        bus.req[7] = 1'b0;
        drain(20);

        // Completion on exactly the last allowed WAIT cycle.
        bram_delay = TO + 1;
        bus.addr[1*AW +: AW] = 32'h100;
        bus.req[1] = 1'b1;
        push_exp(1, bram_word(32'h100));
        wait_gnt(1, 10);
        bus.req[1] = 1'b0;
        drain(600);
        check("race_err", bus.timeout_err, 0);
        bram_delay = 1;

        // Timeout: no completion ever arrives.
        bram_en = 1'b0;
        bus.addr[5*AW +: AW] = 32'h500;
        bus.req[5] = 1'b1;
        push_exp(5, '0);
        wait_gnt(5, 10);
        bus.req[5] = 1'b0;
        n = 0;
        while (!bus.rvalid[5] && n < 600) begin
            tick();
            n++;
        end
        check("to_latency", n, TO + 2);
        check("to_err", bus.timeout_err, 1);
        check("to_rdata", bus.rdata, 0);
        bram_en = 1'b1;
        drain(10);
        bus.addr[6*AW +: AW] = 32'h600;
        bus.req[6] = 1'b1;
        push_exp(6, bram_word(32'h600));
        wait_gnt(6, 10);
        bus.req[6] = 1'b0;
        drain(20);
        check("to_sticky", bus.timeout_err, 1);

        // Reset mid-WAIT, then a stale rd_done.
        bram_en = 1'b0;
        bus.addr[4*AW +: AW] = 32'h400;
        bus.req[4] = 1'b1;
        wait_gnt(4, 10);
        bus.req[4] = 1'b0;
        tick();
        tick();
        rst  = 1'b0;
        pend = 0;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst = 1'b1;
        tick();
        bus.rd_done = 1'b1;
        bus.rd_data = '1;
        tick();
        check("late_busy", bus.busy, 0);
        check("late_rvalid", bus.rvalid, 0);
        check("late_rdata", bus.rdata, 0);
        tick();
        check("late_rvalid2", bus.rvalid, 0);
        bram_en = 1'b1;
        bus.addr[0*AW +: AW] = 32'h010;
        bus.addr[8*AW +: AW] = 32'h810;
        bus.req[0] = 1'b1;
        bus.req[8] = 1'b1;
        push_exp(0, bram_word(32'h010));
        push_exp(8, bram_word(32'h810));
        tick();
        check("rst_first_gnt", bus.gnt, 9'h001);
        bus.req[0] = 1'b0;
        wait_gnt(8, 20);
        bus.req[8] = 1'b0;
        drain(20);

        check("sb_final", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/stream_read_arbiter.md
STREAM_READ_ARBITER -- requirements
Module: stream_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 9: number of requesters sharing the BRAM read port.
REQ-002 Parameter ADDR_W, default 32: read address width.
REQ-003 Parameter DATA_W, default 128: read data width.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort; counter width is clog2(TIMEOUT+1).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 req  in  NUM_REQ  per-requester read request, held high until the matching gnt bit.
REQ-008 addr  in  NUM_REQ*ADDR_W  per-requester address, slice i = addr[i*ADDR_W +: ADDR_W], stable while req[i] high.
REQ-009 gnt  out  NUM_REQ  one-hot, single-cycle pulse: address of requester i accepted.
REQ-010 rvalid  out  NUM_REQ  one-hot: rdata valid for requester i.
REQ-011 rready  in  NUM_REQ  per-requester response acceptance.
REQ-012 rdata  out  DATA_W  shared registered response data.
REQ-013 rd_start  out  1  single-cycle BRAM read strobe.
REQ-014 rd_addr  out  ADDR_W  BRAM read address, registered.
REQ-015 rd_data  in  DATA_W  BRAM read data, valid when rd_done is high.
REQ-016 rd_done  in  1  single-cycle BRAM completion pulse.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 timeout_err  out  1  sticky flag: at least one read aborted.

Function
REQ-019 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE with exactly one outstanding BRAM read.
REQ-020 IDLE: when any req bit is high, the block SHALL select winner index idx by round-robin, searching from pointer ptr upward modulo NUM_REQ, latch idx and addr[idx] into rd_addr, and go to ISSUE.
REQ-021 IDLE with req all zero: the block SHALL stay in IDLE with no output change.
REQ-022 ISSUE (one cycle): gnt[idx]=1 and rd_start=1 in the same cycle; next state WAIT; the wait counter SHALL be cleared to 0.
REQ-023 WAIT: rd_done=1 SHALL load rdata<=rd_data and move to RESP; otherwise the counter SHALL increment each cycle.
REQ-024 WAIT with counter==TIMEOUT and rd_done=0: the block SHALL load rdata<=0, set timeout_err, and move to RESP.
REQ-025 When rd_done and the timeout condition occur in the same cycle, rd_done SHALL win and timeout_err SHALL be unchanged.
REQ-026 RESP: rvalid[idx]=1 until rready[idx]=1; on that cycle the block SHALL set ptr<=(idx+1) mod NUM_REQ and go to IDLE; rready bits other than idx SHALL be ignored.
REQ-027 rd_done outside WAIT SHALL be ignored: no state, data or flag change.
REQ-028 Minimum latency: req sampled high in cycle 0 (IDLE); gnt/rd_start in cycle 1; rd_done in cycle 2 gives rvalid in cycle 3; accept in cycle 3 gives IDLE in cycle 4 and the next ISSUE in cycle 5.
REQ-029 gnt, rvalid and rd_start SHALL each be one-hot or zero in every cycle, and never asserted in the same cycle as RESP->IDLE.
REQ-030 A requester that drops req before gnt SHALL simply not be granted; the winner is fixed once ISSUE is entered.
REQ-031 rd_addr and rdata SHALL hold their values outside their load cycles.

Reset
REQ-032 rst low SHALL immediately force state=IDLE, ptr=0, counter=0, rd_addr=0, rdata=0, gnt=0, rvalid=0, rd_start=0, busy=0, timeout_err=0, independent of clk.
REQ-033 Reset in any state, mid-read included, SHALL abandon the transaction without a response; a late rd_done after release SHALL be ignored per REQ-027.
REQ-034 After rst release, the first arbitration SHALL start the search at requester 0.

Verification
REQ-035 Single request: req[3]=1, addr slice 3=0x0000_0040, rd_done one cycle after rd_start with rd_data=0xA5..A5 -> gnt[3] in cycle 1, rd_addr=0x40, rvalid[3] in cycle 3, rdata=0xA5..A5.
REQ-036 Fairness: all 9 req held high, immediate rd_done and rready -> grant order 0,1,...,8,0; no requester granted twice before all others.
REQ-037 Timeout: req[5]=1, rd_done never asserted -> rvalid[5] after TIMEOUT+1 WAIT cycles, rdata=0, timeout_err=1 and still 1 after the next successful read.
REQ-038 Backpressure: rready[2]=0 for 10 cycles during RESP -> rvalid[2] and rdata stable, busy=1, no gnt issued; rready[2]=1 -> IDLE on the next cycle.
REQ-039 Reset mid-WAIT: rst low for 1 cycle during WAIT, then rd_done pulse -> all outputs 0, no rvalid, next req[0] granted first.
REQ-040 Race: rd_done in the same cycle the counter reaches TIMEOUT -> rdata=rd_data and timeout_err stays 0.
